// File: rtl/usb_rx_timer.sv
// USB receive bit timer: paces bit sampling and counts bits per byte while a packet is being received.
// Optional macro RX_EDGE_RESYNC_EN re-aligns the bit phase to each detected line transition.
module usb_rx_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rcving,
    input  logic       d_edge,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [3:0] bit_count
);

    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic          state_reg, state_next;
    logic [PW-1:0] phase_reg, phase_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic          byte_rx_reg, byte_rx_next;
    logic          shift_now;

    // Sampling strobe comes from registered state only, so no input reaches the outputs combinationally.
    assign shift_now     = (state_reg == RUN) && (phase_reg == PHASE_SAMPLE);
    assign shift_enable  = shift_now;
    assign byte_received = byte_rx_reg;
    assign bit_count     = {1'b0, bit_cnt_reg};

`ifndef RX_EDGE_RESYNC_EN
    logic unused_d_edge;
    assign unused_d_edge = d_edge;
`endif

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        bit_cnt_next = bit_cnt_reg;
        byte_rx_next = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next   = '0;
                bit_cnt_next = '0;
                if (rcving) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!rcving) begin
                    // Dropping reception discards any partial byte, even on a sampling cycle.
                    state_next   = IDLE;
                    phase_next   = '0;
                    bit_cnt_next = '0;
                end else begin
                    if (phase_reg == PHASE_LAST) begin
                        phase_next = '0;
                    end else begin
                        phase_next = phase_reg + PW'(1);
                    end
`ifdef RX_EDGE_RESYNC_EN
                    // The transition cycle counts as phase 0, so the following cycle is phase 1.
                    if (d_edge) begin
                        phase_next = PW'(1);
                    end
`endif
                    if (shift_now) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        byte_rx_next = (bit_cnt_reg == 3'd7);
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                phase_next   = '0;
                bit_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            phase_reg   <= '0;
            bit_cnt_reg <= '0;
            byte_rx_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            bit_cnt_reg <= bit_cnt_next;
            byte_rx_reg <= byte_rx_next;
        end
    end

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer (CLKS_PER_BIT=8, SAMPLE_PHASE=3), with or without RX_EDGE_RESYNC_EN.
module tb_usb_rx_timer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rcving = 1'b0;
    logic       d_edge = 1'b0;
    logic       shift_enable;
    logic       byte_received;
    logic [3:0] bit_count;

    usb_rx_timer #(
        .CLKS_PER_BIT(8),
        .SAMPLE_PHASE(3)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rcving       (rcving),
        .d_edge       (d_edge),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_count    (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rc;
        logic       de;
        logic       se;
        logic       br;
        logic [3:0] bc;
    } vec_t;

    typedef struct {
        logic       se;
        logic       br;
        logic [3:0] bc;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, queue expectation, sample #1 after the edge and compare.
    task automatic step(input logic rc, input logic de, input logic se, input logic br,
                        input logic [3:0] bc, input string tag);
        exp_t e;
        rcving = rc;
        d_edge = de;
        e.se = se;
        e.br = br;
        e.bc = bc;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        d_edge = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s shift_enable", e.tag), {3'b0, shift_enable}, {3'b0, e.se});
            check($sformatf("%s byte_received", e.tag), {3'b0, byte_received}, {3'b0, e.br});
            check($sformatf("%s bit_count", e.tag), bit_count, e.bc);
        end
        $display("step %s rc=%0d de=%0d se=%0d br=%0d bc=%0d", tag, rc, de,
                 shift_enable, byte_received, bit_count);
    endtask

    // rcving held high for n edges from IDLE; optional d_edge pulse sampled at edge edge_at.
    task automatic run_seq(input int n, input int edge_at, input string tag);
        int         cnt;
        int         anchor;
        logic       prev_se;
        logic       se;
        logic       br;
        logic       de;
        logic [3:0] bc;
        cnt = 0;
        anchor = 3;
        prev_se = 1'b0;
        for (int k = 0; k < n; k++) begin
            de = (k == edge_at);
`ifdef RX_EDGE_RESYNC_EN
            if (edge_at >= 0 && k > edge_at) anchor = edge_at + 2;
`endif
            se = (k >= anchor) && (((k - anchor) % 8) == 0);
            br = prev_se && ((cnt % 8) == 0);
            bc = 4'(cnt % 8);
            step(1'b1, de, se, br, bc, $sformatf("%s e%0d", tag, k));
            if (se) cnt++;
            prev_se = se;
        end
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        // Reset is asserted before any clock edge, so outputs must already be cleared.
        #3;
        check("reset shift_enable", {3'b0, shift_enable}, 4'd0);
        check("reset byte_received", {3'b0, byte_received}, 4'd0);
        check("reset bit_count", bit_count, 4'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rc, tbl[i].de, tbl[i].se, tbl[i].br, tbl[i].bc, $sformatf("tbl%0d", i));
        end

        // Two full bytes, then drop.
        run_seq(130, -1, "two_bytes");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "two_bytes drop");

        // Drop after five shifts.
        run_seq(42, -1, "partial");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "partial drop e42");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "partial idle");

        // Drop on the same cycle the eighth shift is presented.
        run_seq(60, -1, "drop8");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "drop8 drop e60");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "drop8 idle");

        // Asynchronous reset between edges 30 and 31, then restart.
        run_seq(31, -1, "rst");
        #2;
        n_rst = 1'b0;
        rcving = 1'b0;
        #1;
        check("async rst shift_enable", {3'b0, shift_enable}, 4'd0);
        check("async rst byte_received", {3'b0, byte_received}, 4'd0);
        check("async rst bit_count", bit_count, 4'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "post_rst idle");
        run_seq(70, -1, "restart");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "restart drop");

        // d_edge sampled at phase 6 of bit 2 (edge 23).
        run_seq(70, 23, "resync");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "resync drop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
